// File: rtl/snes_pad_tx.sv
// SNES pad emulator: drives the pad data line from the console's latch/clock,
// behaving like a 4021-style parallel-load shift register fed by a one-deep frame buffer.
module snes_pad_tx #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILTER_LEN  = 4,
  parameter int unsigned NUM_BITS    = 16,
  parameter logic        FILL_LEVEL  = 1'b0,
  parameter logic [15:0] TIMEOUT     = 16'd4095
) (
  input  logic        CLK_i,
  input  logic        NRST_i,
  input  logic        CTRL_LATCH_i,
  input  logic        CTRL_CLK_i,
  output logic        CTRL_SDATA_o,
  input  logic [15:0] pdata_i,
  input  logic        pdata_valid_i,
  output logic        pdata_ready_o,
  output logic        frame_done_o,
  output logic        timeout_o,
  output logic [4:0]  bit_cnt_o
);

  localparam int unsigned DATA_W = 16;
  localparam int unsigned CNT_W  = 5;
  localparam int unsigned TMO_W  = 16;
  localparam int unsigned FCNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} state_t;

  logic [SYNC_STAGES-1:0] lat_sync_q, lat_sync_d, clk_sync_q, clk_sync_d;
  logic [FCNT_W-1:0]      lat_fcnt_q, lat_fcnt_d, clk_fcnt_q, clk_fcnt_d;
  logic                   lat_filt_q, lat_filt_d, clk_filt_q, clk_filt_d;
  logic                   lat_prev_q, clk_prev_q;
  logic                   lat_s, clk_s, lat_rise, lat_fall, clk_rise;

  state_t                 state_q, state_d;
  logic [DATA_W-1:0]      pending_q, pending_d, shift_q, shift_d;
  logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [TMO_W-1:0]       tmo_cnt_q, tmo_cnt_d;
  logic                   sdata_q, sdata_d, ready_q, ready_d;
  logic                   done_q, done_d, tmo_q, tmo_d;

  assign lat_s    = lat_sync_q[SYNC_STAGES-1];
  assign clk_s    = clk_sync_q[SYNC_STAGES-1];
  assign lat_rise = lat_filt_q & ~lat_prev_q;
  assign lat_fall = ~lat_filt_q & lat_prev_q;
  assign clk_rise = clk_filt_q & ~clk_prev_q;

  // Synchronisers and glitch filters: a level is accepted after FILTER_LEN equal differing samples
  always_comb begin
    lat_sync_d = {lat_sync_q[SYNC_STAGES-2:0], CTRL_LATCH_i};
    clk_sync_d = {clk_sync_q[SYNC_STAGES-2:0], CTRL_CLK_i};
    lat_filt_d = lat_filt_q;
    lat_fcnt_d = '0;
    clk_filt_d = clk_filt_q;
    clk_fcnt_d = '0;
    if (lat_s != lat_filt_q) begin
      if (lat_fcnt_q == FCNT_W'(FILTER_LEN - 1)) lat_filt_d = lat_s;
      else lat_fcnt_d = lat_fcnt_q + FCNT_W'(1);
    end
    if (clk_s != clk_filt_q) begin
      if (clk_fcnt_q == FCNT_W'(FILTER_LEN - 1)) clk_filt_d = clk_s;
      else clk_fcnt_d = clk_fcnt_q + FCNT_W'(1);
    end
  end

  // Frame FSM; latch rise has top priority and restarts from any state
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    sdata_d   = sdata_q;
    tmo_cnt_d = '0;
    done_d    = 1'b0;
    tmo_d     = 1'b0;
    pending_d = (pdata_valid_i && ready_q) ? pdata_i : pending_q;
    if (lat_rise) begin
      state_d   = S_LOAD;
      shift_d   = pending_d;
      bit_cnt_d = '0;
      sdata_d   = ~pending_d[0];
    end else begin
      unique case (state_q)
        S_IDLE: sdata_d = 1'b1;
        S_LOAD: begin
          shift_d   = pending_q;
          bit_cnt_d = '0;
          sdata_d   = ~pending_q[0];
          if (lat_fall) state_d = S_SHIFT;
        end
        S_SHIFT: begin
          if (clk_rise) begin
            shift_d   = shift_q >> 1;
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            if (bit_cnt_d == CNT_W'(NUM_BITS)) begin
              state_d = S_DONE;
              done_d  = 1'b1;
              sdata_d = FILL_LEVEL;
            end else begin
              sdata_d = ~shift_d[0];
            end
          end else begin
            tmo_cnt_d = (tmo_cnt_q == '1) ? tmo_cnt_q : tmo_cnt_q + TMO_W'(1);
            if (tmo_cnt_d >= TIMEOUT) begin
              state_d   = S_IDLE;
              tmo_d     = 1'b1;
              bit_cnt_d = '0;
              sdata_d   = 1'b1;
              tmo_cnt_d = '0;
            end
          end
        end
        S_DONE: sdata_d = FILL_LEVEL;
        default: state_d = S_IDLE;
      endcase
    end
    ready_d = (state_d != S_LOAD);
  end

  always_ff @(posedge CLK_i) begin
    if (!NRST_i) begin
      lat_sync_q <= '0;
      clk_sync_q <= '1;
      lat_fcnt_q <= '0;
      clk_fcnt_q <= '0;
      lat_filt_q <= 1'b0;
      clk_filt_q <= 1'b1;
      lat_prev_q <= 1'b0;
      clk_prev_q <= 1'b1;
      state_q    <= S_IDLE;
      pending_q  <= '0;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      tmo_cnt_q  <= '0;
      sdata_q    <= 1'b1;
      ready_q    <= 1'b0;
      done_q     <= 1'b0;
      tmo_q      <= 1'b0;
    end else begin
      lat_sync_q <= lat_sync_d;
      clk_sync_q <= clk_sync_d;
      lat_fcnt_q <= lat_fcnt_d;
      clk_fcnt_q <= clk_fcnt_d;
      lat_filt_q <= lat_filt_d;
      clk_filt_q <= clk_filt_d;
      lat_prev_q <= lat_filt_q;
      clk_prev_q <= clk_filt_q;
      state_q    <= state_d;
      pending_q  <= pending_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
      sdata_q    <= sdata_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
      tmo_q      <= tmo_d;
    end
  end

  assign CTRL_SDATA_o  = sdata_q;
  assign pdata_ready_o = ready_q;
  assign frame_done_o  = done_q;
  assign timeout_o     = tmo_q;
  assign bit_cnt_o     = bit_cnt_q;

endmodule

// File: tb/tb_snes_pad_tx.sv
// Bench for snes_pad_tx: table of frames plus hand-written glitch, restart, timeout,
// buffer-handshake and reset sequences; expected wire bits go through a scoreboard queue.
`timescale 1ns/1ps
module tb_snes_pad_tx;

  localparam bit FILL = 1'b0;

  logic        clk;
  logic        nrst;
  logic        latch_in;
  logic        pclk_in;
  logic        sdata;
  logic [15:0] pdata;
  logic        pvalid;
  logic        pready;
  logic        fdone;
  logic        tmo;
  logic [4:0]  bcnt;

  typedef struct {
    logic [15:0] pdata;
    logic [15:0] wire_word;
  } vec_t;

  vec_t vecs[4];
  bit   exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   done_cnt = 0;
  int   tmo_cnt  = 0;

  snes_pad_tx dut (
    .CLK_i(clk), .NRST_i(nrst), .CTRL_LATCH_i(latch_in), .CTRL_CLK_i(pclk_in),
    .CTRL_SDATA_o(sdata), .pdata_i(pdata), .pdata_valid_i(pvalid),
    .pdata_ready_o(pready), .frame_done_o(fdone), .timeout_o(tmo), .bit_cnt_o(bcnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (fdone) done_cnt++;
    if (tmo) tmo_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_sdata(input string name);
    bit e;
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: scoreboard empty, got sdata=%0b", name, sdata);
    end else begin
      e = exp_q.pop_front();
      check(name, 32'(sdata), 32'(e));
    end
  endtask

  task automatic wait_ready(input string name);
    int k = 0;
    while (!pready && k < 40) begin
      tick();
      k++;
    end
    check(name, 32'(pready), 32'd1);
  endtask

  task automatic send(input logic [15:0] v);
    wait_ready("send_ready");
    pdata  = v;
    pvalid = 1'b1;
    tick();
    pvalid = 1'b0;
  endtask

  task automatic push_frame(input logic [15:0] w);
    for (int i = 0; i < 16; i++) exp_q.push_back(w[i]);
    exp_q.push_back(FILL);
  endtask

  task automatic latch_pulse();
    latch_in = 1'b1;
    repeat (16) tick();
    latch_in = 1'b0;
    repeat (12) tick();
  endtask

  task automatic clk_pulse(input int low);
    pclk_in = 1'b0;
    repeat (low) tick();
    pclk_in = 1'b1;
    repeat (12) tick();
  endtask

  task automatic shift_bits(input int first, input int n);
    for (int i = first; i < first + n; i++) begin
      check_sdata($sformatf("bit%0d", i));
      check($sformatf("cnt%0d", i), 32'(bcnt), 32'(i));
      clk_pulse(10);
    end
  endtask

  task automatic finish_frame(input int base_done);
    shift_bits(0, 16);
    check_sdata("fill");
    check("cnt_full", 32'(bcnt), 32'd16);
    check("done_pulses", 32'(done_cnt - base_done), 32'd1);
  endtask

  task automatic run_frame(input logic [15:0] w);
    int base;
    push_frame(w);
    latch_pulse();
    base = done_cnt;
    finish_frame(base);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int k;
    vecs[0] = '{16'h0081, 16'hFF7E};
    vecs[1] = '{16'hA5C3, 16'h5A3C};
    vecs[2] = '{16'hFFFF, 16'h0000};
    vecs[3] = '{16'h8001, 16'h7FFE};

    nrst = 1'b0; latch_in = 1'b0; pclk_in = 1'b1; pdata = '0; pvalid = 1'b0;
    repeat (3) tick();
    check("rst_sdata", 32'(sdata), 32'd1);
    check("rst_ready", 32'(pready), 32'd0);
    check("rst_done", 32'(fdone), 32'd0);
    check("rst_tmo", 32'(tmo), 32'd0);
    check("rst_cnt", 32'(bcnt), 32'd0);
    nrst = 1'b1;
    repeat (2) tick();
    check("idle_ready", 32'(pready), 32'd1);

    // Empty buffer after reset reads as no buttons pressed
    run_frame(16'hFFFF);

    for (int v = 0; v < 4; v++) begin
      send(vecs[v].pdata);
      run_frame(vecs[v].wire_word);
    end

    // Extra clocks in DONE are ignored
    clk_pulse(10);
    check("done_cnt_hold", 32'(bcnt), 32'd16);
    check("done_fill", 32'(sdata), 32'(FILL));

    // Glitches on the pad clock, then latch restart mid-frame
    send(16'h00F0);
    push_frame(16'hFF0F);
    latch_pulse();
    base = done_cnt;
    shift_bits(0, 3);
    clk_pulse(2);
    check("glitch2_cnt", 32'(bcnt), 32'd3);
    check("glitch2_sdata", 32'(sdata), 32'd1);
    clk_pulse(3);
    check("glitch3_cnt", 32'(bcnt), 32'd3);
    clk_pulse(4);
    check("pulse4_cnt", 32'(bcnt), 32'd4);
    check("pulse4_sdata", 32'(sdata), 32'd0);
    clk_pulse(10);
    check("pre_restart_sdata", 32'(sdata), 32'd0);
    latch_in = 1'b1;
    repeat (10) tick();
    check("restart_cnt", 32'(bcnt), 32'd0);
    check("restart_sdata", 32'(sdata), 32'd1);
    check("restart_ready", 32'(pready), 32'd0);
    check("restart_no_done", 32'(done_cnt - base), 32'd0);
    latch_in = 1'b0;
    repeat (12) tick();
    exp_q.delete();

    // Clocks stop after 3 shifts -> timeout
    for (int i = 0; i < 3; i++) clk_pulse(10);
    check("pre_tmo_cnt", 32'(bcnt), 32'd3);
    base = tmo_cnt;
    k = 0;
    while (!tmo && k < 5000) begin
      tick();
      k++;
    end
    check("tmo_seen", 32'(tmo), 32'd1);
    check("tmo_window", 32'(k >= 4080 && k <= 4100), 32'd1);
    check("tmo_sdata", 32'(sdata), 32'd1);
    check("tmo_cnt_zero", 32'(bcnt), 32'd0);
    tick();
    check("tmo_pulse_width", 32'(tmo_cnt - base), 32'd1);
    check("tmo_ready", 32'(pready), 32'd1);

    // Data offered while latched waits for the shift phase and lands in the next frame
    push_frame(16'hFF0F);
    latch_in = 1'b1;
    repeat (10) tick();
    check("load_ready", 32'(pready), 32'd0);
    pdata  = 16'h0F0F;
    pvalid = 1'b1;
    repeat (6) tick();
    check("load_ready_hold", 32'(pready), 32'd0);
    check("load_sdata_old", 32'(sdata), 32'd1);
    latch_in = 1'b0;
    wait_ready("post_fall_ready");
    tick();
    pvalid = 1'b0;
    repeat (8) tick();
    base = done_cnt;
    finish_frame(base);
    run_frame(16'hF0F0);

    // Reset mid-frame clears outputs and the buffer
    send(16'h1234);
    push_frame(16'hEDCB);
    latch_pulse();
    shift_bits(0, 5);
    exp_q.delete();
    nrst = 1'b0;
    tick();
    check("mid_rst_sdata", 32'(sdata), 32'd1);
    check("mid_rst_ready", 32'(pready), 32'd0);
    check("mid_rst_cnt", 32'(bcnt), 32'd0);
    check("mid_rst_done", 32'(fdone), 32'd0);
    nrst = 1'b1;
    repeat (2) tick();
    run_frame(16'hFFFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
